goertzel_sched: RTL and testbench
=================================

# goertzel_sched

Sequencing controller for the `goertzel_sdf` multi-bin Goertzel engine. It owns the engine's bin table and frame length, and paces an incoming sample stream so that each sample gets the engine's full per-sample cycle budget. It also detects frame completion and collects the engine's `BIN_NUM` result pairs into a tagged, valid-qualified output stream. It sits between the ADC sample FIFO and the engine, and between the engine and the downstream magnitude/phase logic.

## Interface
- `WIDTH`, 12: sample and result width (signed).
- `N_MAX`, 512: maximum frame length; also the k-load sentinel value.
- `BIN_NUM`, 4: number of bins.
- `LOG_N_MAX`, `$clog2(N_MAX)`: index width.
- `SAMPLE_CYCLES`, `4*BIN_NUM+2`: clocks reserved per sample after `o_eng_wr`.
- `DONE_TIMEOUT`, 256: maximum clocks to wait for `i_eng_done`.
- `i_sys_clk`, in, 1: the single clock; all state updates on the rising edge.
- `i_sys_rst`, in, 1: asynchronous active-low reset.
- `i_cfg_wr`, in, 1: write `i_cfg_k` into shadow entry `i_cfg_bin`.
- `i_cfg_bin`, in, `$clog2(BIN_NUM)`: shadow bin index.
- `i_cfg_k`, in, `LOG_N_MAX`: bin frequency index.
- `i_cfg_N`, in, `$clog2(LOG_N_MAX)`: log2 of the frame length, captured at commit.
- `i_cfg_commit`, in, 1: request to load the shadow table into the engine.
- `i_en`, in, 1: enable sample acceptance.
- `i_x`, in, `WIDTH`: input sample.
- `i_x_valid`, in, 1: sample valid.
- `o_x_ready`, out, 1: sample accepted when `i_x_valid & o_x_ready`.
- `o_eng_x`, out, `WIDTH`: sample driven to the engine.
- `o_eng_wr`, out, 1: one-cycle engine write strobe.
- `o_eng_k`, out, `LOG_N_MAX+1`: engine k port.
- `o_eng_N`, out, `$clog2(LOG_N_MAX)`: engine frame-length port.
- `i_eng_y`, in, 2x`WIDTH`: engine result; `[0]` is real, `[1]` is imaginary.
- `i_eng_done`, in, 1: engine frame-done flag.
- `o_bin_valid`, out, 1: result valid, one-cycle pulse per bin.
- `o_bin_idx`, out, `$clog2(BIN_NUM)`: bin index of the current result.
- `o_re`, `o_im`, out, `WIDTH`: result pair.
- `o_cfg_busy`, out, 1: commit pending or load in progress.
- `o_err`, out, 1: sticky done-timeout flag; cleared only by reset.

## Operation
- Reset (asynchronous, active-low) clears the following:
  - all outputs to 0, including `o_eng_k`;
  - the shadow table to 0 and `o_eng_N` to 0;
  - the state to IDLE.
- `i_cfg_wr` updates the shadow table in any state. An update takes effect only at the next commit.
- `i_cfg_commit` sets a `commit_pending` flag. `commit_pending` is acted on only in IDLE or WAIT_SAMPLE when the frame sample count is 0, i.e. at a frame boundary.
- States and transitions:
  - IDLE: wait for reset release. → LOAD_SENT if `commit_pending`, otherwise → WAIT_SAMPLE.
  - LOAD_SENT: drive `o_eng_k = N_MAX` for 1 cycle, and latch `i_cfg_N` into `o_eng_N`. → LOAD_K.
  - LOAD_K: drive `o_eng_k = {1'b0, shadow[i]}` for `i = 0..BIN_NUM-1`, one bin per cycle. Then drive `o_eng_k = 0`, clear `commit_pending`, and go → WAIT_SAMPLE.
  - WAIT_SAMPLE: `o_x_ready = i_en` and no load is pending at the boundary. On handshake, capture `i_x` into `o_eng_x` and go → FEED.
  - FEED: `o_eng_wr = 1` for exactly 1 cycle, increment `samp_cnt`, load `wait_cnt = SAMPLE_CYCLES`. → BUSY.
  - BUSY: decrement `wait_cnt`; at 0, take one of two exits:
    - if `samp_cnt == (1<<o_eng_N)`, clear `samp_cnt` and go → WAIT_DONE;
    - otherwise go → WAIT_SAMPLE.
  - WAIT_DONE: wait for a rising edge of `i_eng_done`, detected against a registered copy of the flag. → COLLECT. If `DONE_TIMEOUT` clocks elapse first, set `o_err` and go → WAIT_SAMPLE.
  - COLLECT: for `BIN_NUM` consecutive cycles starting the cycle after the edge is detected, register `i_eng_y` into `o_re`/`o_im`, pulse `o_bin_valid`, and present `o_bin_idx` = 0,1,…. → WAIT_SAMPLE.
- `o_eng_k` never equals `N_MAX` outside LOAD_SENT.
- `o_cfg_busy = commit_pending | (state in LOAD_SENT, LOAD_K)`.
- A commit received mid-frame is deferred until after COLLECT.
- Simultaneous `i_cfg_wr` and an active LOAD_K read of the same entry: LOAD_K sends the old value.
- The output stream has no backpressure; the consumer must accept 1 result per clock.

## Timing
- Sample acceptance to `o_eng_wr` pulse: 1 cycle.
- Minimum sample interval: `SAMPLE_CYCLES + 2` clocks (20 with defaults).
- Commit to first bin k on `o_eng_k`: 2 cycles from IDLE. The full load takes `BIN_NUM + 1` cycles.
- `o_x_ready` is low in every state except WAIT_SAMPLE.
- `i_en` low blocks new samples only. Frame completion and collection continue.
- Reset mid-frame aborts everything. The engine must be reset alongside this block.

## Test plan
- **Load sequence:** write k = 3, 7, 12, 20 to bins 0–3, N = 3, commit → `o_eng_k` reads 512, 3, 7, 12, 20, 0 on consecutive cycles; `o_eng_N = 3`; `o_cfg_busy` drops after the last k.
- **Pacing:** `i_x_valid` held high with data 1, 2, 3… → `o_eng_wr` pulses exactly 20 clocks apart, and `o_eng_x` matches the data in order.
- **Frame and collection:** with N = 3 and an engine model, 8 samples then `i_eng_done` rising → 4 `o_bin_valid` pulses with idx 0–3, and `o_re`/`o_im` equal the model outputs.
- **Deferred commit:** commit issued after sample 4 of 8 → no `N_MAX` appears on `o_eng_k` until after the 4th result pulse; the new N takes effect on the next frame.
- **Timeout:** `i_eng_done` is never asserted → `o_err` goes to 1 exactly 256 clocks after entering WAIT_DONE, and sample acceptance resumes.
- **Async reset:** `i_sys_rst` driven low mid-BUSY, between clock edges → all outputs go to 0 immediately; after release, no `o_eng_wr` occurs until a new handshake.

Source files
------------

// File: rtl/goertzel_sched.sv
// Sequencer for the goertzel_sdf engine: loads the bin table, paces samples to the
// engine's per-sample budget, and streams the BIN_NUM results out after each frame.
`timescale 1ns/1ps
module goertzel_sched #(
    parameter int WIDTH         = 12,
    parameter int N_MAX         = 512,
    parameter int BIN_NUM       = 4,
    parameter int LOG_N_MAX     = $clog2(N_MAX),
    parameter int SAMPLE_CYCLES = 4*BIN_NUM+2,
    parameter int DONE_TIMEOUT  = 256
) (
    input  logic                              i_sys_clk,
    input  logic                              i_sys_rst,
    input  logic                              i_cfg_wr,
    input  logic        [$clog2(BIN_NUM)-1:0] i_cfg_bin,
    input  logic              [LOG_N_MAX-1:0] i_cfg_k,
    input  logic      [$clog2(LOG_N_MAX)-1:0] i_cfg_N,
    input  logic                              i_cfg_commit,
    input  logic                              i_en,
    input  logic signed           [WIDTH-1:0] i_x,
    input  logic                              i_x_valid,
    output logic                              o_x_ready,
    output logic signed           [WIDTH-1:0] o_eng_x,
    output logic                              o_eng_wr,
    output logic                [LOG_N_MAX:0] o_eng_k,
    output logic      [$clog2(LOG_N_MAX)-1:0] o_eng_N,
    input  logic           [1:0][WIDTH-1:0]   i_eng_y,
    input  logic                              i_eng_done,
    output logic                              o_bin_valid,
    output logic        [$clog2(BIN_NUM)-1:0] o_bin_idx,
    output logic signed           [WIDTH-1:0] o_re,
    output logic signed           [WIDTH-1:0] o_im,
    output logic                              o_cfg_busy,
    output logic                              o_err
);
    localparam int BIN_W = $clog2(BIN_NUM);
    localparam int NW    = $clog2(LOG_N_MAX);
    localparam int K_W   = LOG_N_MAX + 1;
    localparam int WC_W  = $clog2(SAMPLE_CYCLES + 1);
    localparam int TO_W  = $clog2(DONE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, LOAD_SENT, LOAD_K, WAIT_SAMPLE, FEED, BUSY, WAIT_DONE, COLLECT
    } state_t;

    state_t                             state_q, state_d;
    logic [BIN_NUM-1:0][LOG_N_MAX-1:0]  shadow_q, shadow_d;
    logic                               pending_q, pending_d;
    logic [NW-1:0]                      eng_n_q, eng_n_d;
    logic [BIN_W-1:0]                   bin_cnt_q, bin_cnt_d;
    logic [K_W-1:0]                     samp_cnt_q, samp_cnt_d;
    logic [WC_W-1:0]                    wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0]                    to_cnt_q, to_cnt_d;
    logic                               done_q, done_d;
    logic signed [WIDTH-1:0]            eng_x_q, eng_x_d;
    logic                               err_q, err_d;
    logic                               bin_valid_q, bin_valid_d;
    logic [BIN_W-1:0]                   bin_idx_q, bin_idx_d;
    logic signed [WIDTH-1:0]            re_q, re_d, im_q, im_d;
    logic [K_W-1:0]                     frame_len;
    logic                               load_req;

    assign frame_len = K_W'(1) << eng_n_q;
    // A pending commit only wins at a frame boundary, never mid-frame.
    assign load_req  = pending_q && (samp_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q | i_cfg_commit;
        eng_n_d     = eng_n_q;
        bin_cnt_d   = bin_cnt_q;
        samp_cnt_d  = samp_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        to_cnt_d    = to_cnt_q;
        done_d      = i_eng_done;
        eng_x_d     = eng_x_q;
        err_d       = err_q;
        bin_valid_d = 1'b0;
        bin_idx_d   = bin_idx_q;
        re_d        = re_q;
        im_d        = im_q;
        o_x_ready   = 1'b0;
        o_eng_wr    = 1'b0;
        o_eng_k     = '0;
        if (i_cfg_wr) shadow_d[i_cfg_bin] = i_cfg_k;

        case (state_q)
            IDLE: state_d = pending_q ? LOAD_SENT : WAIT_SAMPLE;
            LOAD_SENT: begin
                o_eng_k   = K_W'(N_MAX);
                eng_n_d   = i_cfg_N;
                bin_cnt_d = '0;
                state_d   = LOAD_K;
            end
            LOAD_K: begin
                // Reads the registered table, so a same-cycle write sends the old k.
                o_eng_k = {1'b0, shadow_q[bin_cnt_q]};
                if (bin_cnt_q == BIN_W'(BIN_NUM-1)) begin
                    bin_cnt_d = '0;
                    pending_d = i_cfg_commit;
                    state_d   = WAIT_SAMPLE;
                end else begin
                    bin_cnt_d = bin_cnt_q + 1'b1;
                end
            end
            WAIT_SAMPLE: begin
                if (load_req) begin
                    state_d = LOAD_SENT;
                end else begin
                    o_x_ready = i_en;
                    if (i_en && i_x_valid) begin
                        eng_x_d = i_x;
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                o_eng_wr   = 1'b1;
                samp_cnt_d = samp_cnt_q + 1'b1;
                wait_cnt_d = WC_W'(SAMPLE_CYCLES);
                state_d    = BUSY;
            end
            BUSY: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == WC_W'(1)) begin
                    if (samp_cnt_q == frame_len) begin
                        samp_cnt_d = '0;
                        to_cnt_d   = '0;
                        state_d    = WAIT_DONE;
                    end else begin
                        state_d = WAIT_SAMPLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (i_eng_done && !done_q) begin
                    bin_cnt_d = '0;
                    state_d   = COLLECT;
                end else if (to_cnt_q == TO_W'(DONE_TIMEOUT-1)) begin
                    err_d   = 1'b1;
                    state_d = WAIT_SAMPLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            COLLECT: begin
                re_d        = $signed(i_eng_y[0]);
                im_d        = $signed(i_eng_y[1]);
                bin_valid_d = 1'b1;
                bin_idx_d   = bin_cnt_q;
                if (bin_cnt_q == BIN_W'(BIN_NUM-1)) begin
                    bin_cnt_d = '0;
                    state_d   = WAIT_SAMPLE;
                end else begin
                    bin_cnt_d = bin_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            eng_n_q     <= '0;
            bin_cnt_q   <= '0;
            samp_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            to_cnt_q    <= '0;
            done_q      <= 1'b0;
            eng_x_q     <= '0;
            err_q       <= 1'b0;
            bin_valid_q <= 1'b0;
            bin_idx_q   <= '0;
            re_q        <= '0;
            im_q        <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            eng_n_q     <= eng_n_d;
            bin_cnt_q   <= bin_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            eng_x_q     <= eng_x_d;
            err_q       <= err_d;
            bin_valid_q <= bin_valid_d;
            bin_idx_q   <= bin_idx_d;
            re_q        <= re_d;
            im_q        <= im_d;
        end
    end

    assign o_eng_x     = eng_x_q;
    assign o_eng_N     = eng_n_q;
    assign o_bin_valid = bin_valid_q;
    assign o_bin_idx   = bin_idx_q;
    assign o_re        = re_q;
    assign o_im        = im_q;
    assign o_err       = err_q;
    assign o_cfg_busy  = pending_q || (state_q == LOAD_SENT) || (state_q == LOAD_K);
endmodule

// File: tb/tb_goertzel_sched.sv
// Directed bench for goertzel_sched: load, pacing, collection, deferred commit,
// done timeout and asynchronous reset.
`timescale 1ns/1ps
module tb_goertzel_sched;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_cfg_wr, i_cfg_commit, i_en, i_x_valid, i_eng_done;
    logic [1:0]         i_cfg_bin;
    logic [8:0]         i_cfg_k;
    logic [3:0]         i_cfg_N;
    logic signed [11:0] i_x;
    logic [1:0][11:0]   i_eng_y;
    logic               o_x_ready, o_eng_wr, o_bin_valid, o_cfg_busy, o_err;
    logic signed [11:0] o_eng_x, o_re, o_im;
    logic [9:0]         o_eng_k;
    logic [3:0]         o_eng_N;
    logic [1:0]         o_bin_idx;

    int checks = 0, failures = 0, cyc = 0, wr_cnt = 0, n512 = 0;

    goertzel_sched dut (
        .i_sys_clk(clk), .i_sys_rst(rst_n), .i_cfg_wr(i_cfg_wr), .i_cfg_bin(i_cfg_bin),
        .i_cfg_k(i_cfg_k), .i_cfg_N(i_cfg_N), .i_cfg_commit(i_cfg_commit), .i_en(i_en),
        .i_x(i_x), .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .o_eng_x(o_eng_x),
        .o_eng_wr(o_eng_wr), .o_eng_k(o_eng_k), .o_eng_N(o_eng_N), .i_eng_y(i_eng_y),
        .i_eng_done(i_eng_done), .o_bin_valid(o_bin_valid), .o_bin_idx(o_bin_idx),
        .o_re(o_re), .o_im(o_im), .o_cfg_busy(o_cfg_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (o_eng_wr === 1'b1) wr_cnt <= wr_cnt + 1;
        if (o_eng_k === 10'd512) n512 <= n512 + 1;
    end

    // Offers one sample and reports what the engine port showed on the following cycles.
    task automatic send_sample(input logic signed [11:0] d, input bit keep, output bit got,
                               output int wcyc, output logic wr_now, output logic wr_after,
                               output logic signed [11:0] xs);
        got = 1'b0; wcyc = 0; wr_now = 1'b0; wr_after = 1'b1; xs = '0;
        i_x = d; i_x_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (o_x_ready) got = 1'b1;
        end
        if (got) begin
            @(posedge clk); #1;
            if (!keep) i_x_valid = 1'b0;
            wr_now = o_eng_wr; xs = o_eng_x; wcyc = cyc;
            @(posedge clk); #1;
            wr_after = o_eng_wr;
        end else begin
            i_x_valid = 1'b0;
        end
    endtask

    task automatic write_bin(input logic [1:0] b, input logic [8:0] k);
        i_cfg_wr = 1'b1; i_cfg_bin = b; i_cfg_k = k;
        @(posedge clk); #1;
        i_cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got_vec;
        got_vec = {o_x_ready, o_eng_wr, o_bin_valid, o_cfg_busy, o_err, o_bin_idx, o_eng_N,
                   o_eng_k, o_re[5:0], o_eng_x[4:0]};
        checks++;
        if (got_vec !== 32'd0 || o_re !== 12'sd0 || o_im !== 12'sd0 || o_eng_x !== 12'sd0) begin
            failures++; $display("FAIL reset_outputs: got %h required 0", got_vec);
        end
        rst_n = 1'b1; i_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_x_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready_after_release: got %b required 1", o_x_ready);
        end
    endtask

    task automatic check_load(input int k0, input int k1, input int k2, input int k3, input int n);
        int exp_k[6];
        exp_k = '{512, k0, k1, k2, k3, 0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o_eng_k !== 10'(exp_k[i])) begin
                failures++; $display("FAIL load_k[%0d]: got %0d required %0d", i, o_eng_k, exp_k[i]);
            end
        end
        checks++;
        if (o_eng_N !== 4'(n) || o_cfg_busy !== 1'b0) begin
            failures++;
            $display("FAIL load_done: N=%0d busy=%b required N=%0d busy=0", o_eng_N, o_cfg_busy, n);
        end
    endtask

    task automatic test_load();
        write_bin(2'd0, 9'd3); write_bin(2'd1, 9'd7); write_bin(2'd2, 9'd12); write_bin(2'd3, 9'd20);
        i_cfg_N = 4'd3; i_cfg_commit = 1'b1;
        @(posedge clk); #1;
        i_cfg_commit = 1'b0;
        checks++;
        if (o_cfg_busy !== 1'b1 || o_x_ready !== 1'b0) begin
            failures++;
            $display("FAIL commit_pending: busy=%b ready=%b required busy=1 ready=0", o_cfg_busy, o_x_ready);
        end
        check_load(3, 7, 12, 20, 3);
    endtask

    task automatic test_pacing(input int base, input int cnt, input bit drop_last);
        bit got; int wcyc, prev; logic wn, wa; logic signed [11:0] xs;
        prev = 0;
        for (int i = 0; i < cnt; i++) begin
            send_sample(12'(base + i), !(drop_last && i == cnt - 1), got, wcyc, wn, wa, xs);
            checks++;
            if (!got || wn !== 1'b1 || wa !== 1'b0 || xs !== 12'(base + i)) begin
                failures++;
                $display("FAIL sample[%0d]: got=%b wr=%b wr_next=%b x=%0d required 1 1 0 %0d",
                         i, got, wn, wa, xs, base + i);
            end
            if (i > 0) begin
                checks++;
                if (wcyc - prev !== 20) begin
                    failures++; $display("FAIL wr_interval[%0d]: got %0d required 20", i, wcyc - prev);
                end
            end
            prev = wcyc;
        end
    endtask

    task automatic test_collect(input int base);
        logic signed [11:0] er, ei;
        repeat (20) @(posedge clk); #1;
        checks++;
        if (o_x_ready !== 1'b0) begin
            failures++; $display("FAIL wait_done_ready: got %b required 0", o_x_ready);
        end
        i_eng_done = 1'b1;
        @(posedge clk); #1;
        i_eng_y[0] = 12'(base); i_eng_y[1] = 12'(-(base / 2));
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            er = 12'(base + 17 * b); ei = 12'(-(base / 2) - 5 * b);
            checks++;
            if (o_bin_valid !== 1'b1 || o_bin_idx !== 2'(b) || o_re !== er || o_im !== ei) begin
                failures++;
                $display("FAIL bin[%0d]: v=%b idx=%0d re=%0d im=%0d required 1 %0d %0d %0d",
                         b, o_bin_valid, o_bin_idx, o_re, o_im, b, er, ei);
            end
            i_eng_y[0] = 12'(base + 17 * (b + 1)); i_eng_y[1] = 12'(-(base / 2) - 5 * (b + 1));
        end
        i_eng_done = 1'b0;
    endtask

    task automatic test_frame();
        test_pacing(1, 8, 1'b1);
        test_collect(100);
        @(posedge clk); #1;
        checks++;
        if (o_bin_valid !== 1'b0) begin
            failures++; $display("FAIL valid_after_collect: got %b required 0", o_bin_valid);
        end
    endtask

    task automatic test_deferred();
        int n0;
        test_pacing(21, 4, 1'b0);
        write_bin(2'd0, 9'd5); write_bin(2'd1, 9'd6); write_bin(2'd2, 9'd9); write_bin(2'd3, 9'd10);
        i_cfg_N = 4'd2; i_cfg_commit = 1'b1;
        @(posedge clk); #1;
        i_cfg_commit = 1'b0;
        n0 = n512;
        checks++;
        if (o_cfg_busy !== 1'b1) begin
            failures++; $display("FAIL deferred_busy: got %b required 1", o_cfg_busy);
        end
        test_pacing(25, 4, 1'b1);
        test_collect(200);
        checks++;
        if (n512 !== n0 || o_eng_k === 10'd512) begin
            failures++; $display("FAIL deferred_early_load: sentinel seen %0d times, required 0", n512 - n0);
        end
        check_load(5, 6, 9, 10, 2);
    endtask

    task automatic test_timeout();
        test_pacing(31, 4, 1'b1);
        repeat (273) @(posedge clk); #1;
        checks++;
        if (o_err !== 1'b0 || o_x_ready !== 1'b0) begin
            failures++; $display("FAIL timeout_early: err=%b ready=%b required 0 0", o_err, o_x_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (o_err !== 1'b1 || o_x_ready !== 1'b1) begin
            failures++; $display("FAIL timeout_fire: err=%b ready=%b required 1 1", o_err, o_x_ready);
        end
    endtask

    task automatic test_async_reset();
        bit got; int wcyc, w0; logic wn, wa; logic signed [11:0] xs;
        send_sample(12'sd41, 1'b0, got, wcyc, wn, wa, xs);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({o_x_ready, o_eng_wr, o_bin_valid, o_cfg_busy, o_err} !== 5'd0 || o_eng_k !== 10'd0 ||
            o_eng_N !== 4'd0 || o_eng_x !== 12'sd0 || o_re !== 12'sd0 || o_im !== 12'sd0 ||
            o_bin_idx !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: err=%b x=%0d N=%0d re=%0d required all 0",
                     o_err, o_eng_x, o_eng_N, o_re);
        end
        #2 rst_n = 1'b1;
        w0 = wr_cnt;
        repeat (30) @(posedge clk); #1;
        i_en = 1'b0; i_x_valid = 1'b1; i_x = 12'sd55;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (wr_cnt !== w0 || o_x_ready !== 1'b0) begin
            failures++;
            $display("FAIL no_spurious_wr: wr pulses %0d ready=%b required 0 0", wr_cnt - w0, o_x_ready);
        end
        i_x_valid = 1'b0; i_en = 1'b1;
        send_sample(-12'sd42, 1'b0, got, wcyc, wn, wa, xs);
        checks++;
        if (!got || wn !== 1'b1 || xs !== -12'sd42 || wr_cnt !== w0 + 1) begin
            failures++;
            $display("FAIL resume_after_reset: got=%b wr=%b x=%0d required 1 1 -42", got, wn, xs);
        end
    endtask

    initial begin
        rst_n = 1'b0; i_cfg_wr = 1'b0; i_cfg_commit = 1'b0; i_en = 1'b0; i_x_valid = 1'b0;
        i_eng_done = 1'b0; i_cfg_bin = '0; i_cfg_k = '0; i_cfg_N = '0; i_x = '0; i_eng_y = '0;
        repeat (3) @(posedge clk); #1;
        test_reset();
        test_load();
        test_frame();
        test_deferred();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
